pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: the PC value loaded on reset.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req_valid  output  1  instruction-memory read request is valid.
REQ-005 imem_req_ready  input  1  memory accepts the request.
REQ-006 imem_addr  output  32  read address; SHALL equal pc.
REQ-007 imem_rsp_valid  input  1  read data is valid.
REQ-008 imem_rsp_data  input  32  instruction word returned by memory.
REQ-009 instr_valid  output  1  instr is held and valid for the decode stage.
REQ-010 instr_ready  input  1  decode stage accepts instr this cycle.
REQ-011 instr  output  32  captured instruction word.
REQ-012 imm16  output  16  instr[15:0]; feeds the immediate extender.
REQ-013 pc  output  32  address of the current or held instruction.
REQ-014 pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-015 br_taken  input  1  branch taken for the held instruction.
REQ-016 br_offset  input  32  extender output (mode 2'b11: sign-extended imm16 shifted left 2); a byte offset.
REQ-017 jump  input  1  j/jal redirect for the held instruction.
REQ-018 j_index  input  26  jump index field.
REQ-019 jr  input  1  register-indirect redirect for the held instruction.
REQ-020 jr_target  input  32  register jump target.

Function
REQ-021 The FSM SHALL have three states: REQ, WAIT and HOLD, encoded in 2 bits; the unused encoding SHALL go to REQ.
REQ-022 In REQ, imem_req_valid SHALL be 1; on imem_req_valid && imem_req_ready, the next state SHALL be WAIT; otherwise it SHALL stay REQ with imem_addr unchanged.
REQ-023 In WAIT, on imem_rsp_valid, instr SHALL capture imem_rsp_data and the next state SHALL be HOLD; otherwise it SHALL stay WAIT.
REQ-024 imem_rsp_valid SHALL be ignored in REQ and HOLD; a response can never be accepted in the same cycle as its request.
REQ-025 instr_valid SHALL be 1 exactly in HOLD; instr and imm16 SHALL stay stable while instr_valid && !instr_ready.
REQ-026 In HOLD with instr_ready=1, pc SHALL load next_pc and the next state SHALL be REQ; redirect inputs SHALL be sampled only in this cycle and ignored otherwise.
REQ-027 next_pc priority SHALL be jr, then jump, then br_taken, then sequential.
REQ-028 jr: next_pc = {jr_target[31:2], 2'b00}.
REQ-029 jump: next_pc = {pc_plus4[31:28], j_index, 2'b00}.
REQ-030 br_taken: next_pc = pc_plus4 + br_offset, 32-bit wrap-around, carry discarded.
REQ-031 sequential: next_pc = pc_plus4; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-032 There SHALL be no delay slot; the redirect target is the very next fetch.
REQ-033 Minimum latency, with ready and response both immediate, SHALL be REQ, WAIT, HOLD: instr_valid is asserted 2 cycles after the request is issued, giving 3 cycles per instruction.

Reset
REQ-034 rst_n=0 SHALL immediately, without waiting for a clock edge, set state=REQ, pc=RESET_PC, instr=32'h0, imem_req_valid=1 and instr_valid=0.
REQ-035 Reset in WAIT SHALL drop the outstanding request; a response arriving in the first cycle after reset SHALL NOT be captured, because state is REQ.
REQ-036 Reset deassertion SHALL be synchronised by the integrator; the block needs no internal reset counter.

Verification
REQ-037 Reset release, ready=1, response 1 cycle after the request with data 32'h3C01_1234 -> imem_addr=32'h3000, instr_valid high 2 cycles after the request, imm16=16'h1234, pc_plus4=32'h3004.
REQ-038 Hold instr_ready=0 for 5 cycles -> instr, pc and instr_valid stay constant and no new request is issued; then instr_ready=1 with no redirect -> next request addr 32'h3004.
REQ-039 pc=32'h3010, br_taken=1, br_offset=32'hFFFF_FFF0 -> next fetch addr 32'h3004; br_offset=32'h0000_0008 -> 32'h301C.
REQ-040 jr=1, jump=1 and br_taken=1 all in one accept cycle, jr_target=32'h0000_4007 -> next addr 32'h4004; jump alone with j_index=26'h0000100 and pc=32'h3000 -> 32'h0000_0400.
REQ-041 imem_req_ready held 0 for 4 cycles -> imem_req_valid stays 1 and imem_addr stays stable; imem_rsp_valid pulsed during REQ -> ignored.
REQ-042 Assert rst_n=0 mid-WAIT, then release -> the next request addr is RESET_PC, and a stale response in the first cycle after release is not captured.

Source files
------------

// File: rtl/pc_fetch.sv
// PC and instruction fetch stage: issues one imem read per instruction,
// holds the returned word for decode and computes the next PC on accept.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [15:0] imm16,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        br_taken,
    input  logic [31:0] br_offset,
    input  logic        jump,
    input  logic [25:0] j_index,
    input  logic        jr,
    input  logic [31:0] jr_target
);

    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_WAIT = 2'b01,
        S_HOLD = 2'b10
    } state_t;

    state_t      state;
    logic [31:0] next_pc;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign imm16     = instr[15:0];

    // Redirect target: register jump beats j/jal beats branch beats sequential.
    always_comb begin
        next_pc = pc_plus4;
        priority case (1'b1)
            jr:       next_pc = {jr_target[31:2], 2'b00};
            jump:     next_pc = {pc_plus4[31:28], j_index, 2'b00};
            br_taken: next_pc = pc_plus4 + br_offset;
            default:  next_pc = pc_plus4;
        endcase
    end

    // Fetch FSM with registered handshake outputs; pc only moves on decode accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_REQ;
            pc             <= RESET_PC;
            instr          <= 32'h0;
            imem_req_valid <= 1'b1;
            instr_valid    <= 1'b0;
        end else begin
            unique case (state)
                S_REQ: begin
                    if (imem_req_valid && imem_req_ready) begin
                        state          <= S_WAIT;
                        imem_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        instr       <= imem_rsp_data;
                        state       <= S_HOLD;
                        instr_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        pc             <= next_pc;
                        state          <= S_REQ;
                        instr_valid    <= 1'b0;
                        imem_req_valid <= 1'b1;
                    end
                end
                default: begin
                    state          <= S_REQ;
                    imem_req_valid <= 1'b1;
                    instr_valid    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed testbench for pc_fetch: handshake timing, stalls, redirects,
// wrap-around and asynchronous reset.
module tb_pc_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [15:0] imm16;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        br_taken;
    logic [31:0] br_offset;
    logic        jump;
    logic [25:0] j_index;
    logic        jr;
    logic [31:0] jr_target;

    int total;
    int bad;
    logic [31:0] last_data;

    pc_fetch #(.RESET_PC(32'h0000_3000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .imm16          (imm16),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .br_taken       (br_taken),
        .br_offset      (br_offset),
        .jump           (jump),
        .j_index        (j_index),
        .jr             (jr),
        .jr_target      (jr_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full request/response with zero wait: REQ -> WAIT -> HOLD.
    task automatic fetch(input logic [31:0] data);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        last_data      = data;
    endtask

    // Decode accepts the held instruction with the given redirect inputs.
    task automatic accept(input logic i_jr, input logic [31:0] i_jrt,
                          input logic i_j, input logic [25:0] i_idx,
                          input logic i_br, input logic [31:0] i_off);
        jr          = i_jr;
        jr_target   = i_jrt;
        jump        = i_j;
        j_index     = i_idx;
        br_taken    = i_br;
        br_offset   = i_off;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        jr          = 1'b0;
        jump        = 1'b0;
        br_taken    = 1'b0;
    endtask

    task automatic seq_step();
        fetch(32'h0000_0000);
        accept(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (imem_req_valid !== 1'b1) begin
            bad++; $display("FAIL rst_req_valid got=%b exp=1", imem_req_valid);
        end
        total++;
        if (instr_valid !== 1'b0) begin
            bad++; $display("FAIL rst_instr_valid got=%b exp=0", instr_valid);
        end
        total++;
        if (imem_addr !== 32'h0000_3000) begin
            bad++; $display("FAIL rst_addr got=%h exp=00003000", imem_addr);
        end
        total++;
        if (instr !== 32'h0) begin
            bad++; $display("FAIL rst_instr got=%h exp=00000000", instr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        imem_req_ready = 1'b1;
        total++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0000_3000) begin
            bad++; $display("FAIL basic_req got=%b/%h exp=1/00003000",
                            imem_req_valid, imem_addr);
        end
        @(negedge clk);
        imem_req_ready = 1'b0;
        total++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL basic_wait got=%b/%b exp=0/0",
                            imem_req_valid, instr_valid);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h3C01_1234;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        last_data      = 32'h3C01_1234;
        total++;
        if (instr_valid !== 1'b1) begin
            bad++; $display("FAIL basic_valid got=%b exp=1", instr_valid);
        end
        total++;
        if (imm16 !== 16'h1234 || instr !== 32'h3C01_1234) begin
            bad++; $display("FAIL basic_instr got=%h/%h exp=3c011234/1234",
                            instr, imm16);
        end
        total++;
        if (pc_plus4 !== 32'h0000_3004 || pc !== 32'h0000_3000) begin
            bad++; $display("FAIL basic_pc got=%h/%h exp=00003000/00003004",
                            pc, pc_plus4);
        end
    endtask

    task automatic test_stall();
        instr_ready = 1'b0;
        jr = 1'b1; jr_target = 32'h0000_5000;
        jump = 1'b1; j_index = 26'h3FF_FFFF;
        br_taken = 1'b1; br_offset = 32'h0000_0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (instr_valid !== 1'b1 || imem_req_valid !== 1'b0 ||
                instr !== 32'h3C01_1234 || pc !== 32'h0000_3000) begin
                bad++; $display("FAIL stall_hold%0d got=%b/%b/%h/%h exp=1/0/3c011234/00003000",
                                i, instr_valid, imem_req_valid, instr, pc);
            end
        end
        jr = 1'b0; jump = 1'b0; br_taken = 1'b0;
        accept(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        total++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0000_3004 ||
            instr_valid !== 1'b0) begin
            bad++; $display("FAIL stall_next got=%b/%h/%b exp=1/00003004/0",
                            imem_req_valid, imem_addr, instr_valid);
        end
    endtask

    task automatic test_branch();
        repeat (3) seq_step();
        total++;
        if (imem_addr !== 32'h0000_3010) begin
            bad++; $display("FAIL br_setup got=%h exp=00003010", imem_addr);
        end
        fetch(32'h1000_FFFC);
        accept(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFF0);
        total++;
        if (imem_addr !== 32'h0000_3004) begin
            bad++; $display("FAIL br_back got=%h exp=00003004", imem_addr);
        end
        repeat (3) seq_step();
        fetch(32'h1000_0002);
        accept(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h0000_0008);
        total++;
        if (imem_addr !== 32'h0000_301C) begin
            bad++; $display("FAIL br_fwd got=%h exp=0000301c", imem_addr);
        end
    endtask

    task automatic test_jumps();
        fetch(32'h0000_0008);
        accept(1'b1, 32'h0000_4007, 1'b1, 26'h3FF_FFFF, 1'b1, 32'h0000_0100);
        total++;
        if (imem_addr !== 32'h0000_4004) begin
            bad++; $display("FAIL jr_prio got=%h exp=00004004", imem_addr);
        end
        fetch(32'h0000_0008);
        accept(1'b1, 32'h0000_3000, 1'b0, 26'h0, 1'b0, 32'h0);
        fetch(32'h0800_0100);
        accept(1'b0, 32'h0, 1'b1, 26'h000_0100, 1'b1, 32'h0000_0040);
        total++;
        if (imem_addr !== 32'h0000_0400) begin
            bad++; $display("FAIL jump got=%h exp=00000400", imem_addr);
        end
    endtask

    task automatic test_wrap();
        fetch(32'h0000_0008);
        accept(1'b1, 32'hFFFF_FFFF, 1'b0, 26'h0, 1'b0, 32'h0);
        total++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_jr got=%h exp=fffffffc", imem_addr);
        end
        fetch(32'h0000_0000);
        total++;
        if (pc_plus4 !== 32'h0000_0000) begin
            bad++; $display("FAIL wrap_pc4 got=%h exp=00000000", pc_plus4);
        end
        accept(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
        total++;
        if (imem_addr !== 32'h0000_0000) begin
            bad++; $display("FAIL wrap_seq got=%h exp=00000000", imem_addr);
        end
    endtask

    task automatic test_req_stall();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            imem_rsp_valid = (i == 1);
            imem_rsp_data  = 32'hDEAD_BEEF;
            @(negedge clk);
            total++;
            if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0000_0000 ||
                instr_valid !== 1'b0 || instr !== last_data) begin
                bad++; $display("FAIL req_stall%0d got=%b/%h/%b/%h exp=1/00000000/0/%h",
                                i, imem_req_valid, imem_addr, instr_valid,
                                instr, last_data);
            end
        end
        imem_rsp_valid = 1'b0;
        fetch(32'h1111_2222);
        total++;
        if (instr_valid !== 1'b1 || instr !== 32'h1111_2222) begin
            bad++; $display("FAIL req_stall_fetch got=%b/%h exp=1/11112222",
                            instr_valid, instr);
        end
        accept(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back();
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h00A0_0001;
        instr_ready    = 1'b1;
        for (int k = 0; k < 6; k++) begin
            total++;
            if (instr_valid !== (k % 3 == 2)) begin
                bad++; $display("FAIL b2b_valid%0d got=%b exp=%b",
                                k, instr_valid, (k % 3 == 2));
            end
            if (k % 3 == 0) begin
                total++;
                if (imem_addr !== 32'd4 + 32'd4 * (k / 3)) begin
                    bad++; $display("FAIL b2b_addr%0d got=%h exp=%h",
                                    k, imem_addr, 32'd4 + 32'd4 * (k / 3));
                end
            end
            @(negedge clk);
        end
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        instr_ready    = 1'b0;
        last_data      = 32'h00A0_0001;
        total++;
        if (imem_addr !== 32'h0000_000C || imem_req_valid !== 1'b1) begin
            bad++; $display("FAIL b2b_end got=%h/%b exp=0000000c/1",
                            imem_addr, imem_req_valid);
        end
    endtask

    task automatic test_reset_mid_wait();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        total++;
        if (imem_req_valid !== 1'b0) begin
            bad++; $display("FAIL mid_wait got=%b exp=0", imem_req_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (imem_req_valid !== 1'b1 || instr_valid !== 1'b0 ||
            imem_addr !== 32'h0000_3000 || instr !== 32'h0) begin
            bad++; $display("FAIL mid_rst got=%b/%b/%h/%h exp=1/0/00003000/00000000",
                            imem_req_valid, instr_valid, imem_addr, instr);
        end
        @(negedge clk);
        rst_n          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBADC_0DE0;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 ||
            imem_req_valid !== 1'b1 || imem_addr !== 32'h0000_3000) begin
            bad++; $display("FAIL mid_stale got=%b/%h/%b/%h exp=0/00000000/1/00003000",
                            instr_valid, instr, imem_req_valid, imem_addr);
        end
        fetch(32'h1234_5678);
        total++;
        if (instr !== 32'h1234_5678 || pc !== 32'h0000_3000 ||
            instr_valid !== 1'b1) begin
            bad++; $display("FAIL mid_refetch got=%h/%h/%b exp=12345678/00003000/1",
                            instr, pc, instr_valid);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        last_data      = 32'h0;
        rst_n          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b0;
        br_taken       = 1'b0;
        br_offset      = 32'h0;
        jump           = 1'b0;
        j_index        = 26'h0;
        jr             = 1'b0;
        jr_target      = 32'h0;
        test_reset();
        test_basic();
        test_stall();
        test_branch();
        test_jumps();
        test_wrap();
        test_req_stall();
        test_back_to_back();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
